// File: rtl/sub_bytes_pipe.sv
// Multi-lane pipelined AES SubBytes over a GF((2^4)^2) tower field.
// Define SBOX_INV_EN to add the in_inv port and per-beat InvSubBytes.
module sub_bytes_pipe #(
  parameter int LANES       = 4,
  parameter int PIPE_STAGES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] in_data,
`ifdef SBOX_INV_EN
  input  logic               in_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [8*LANES-1:0] out_data,
  output logic               busy
);

  localparam int W  = 8 * LANES;
  localparam int XW = 12 * LANES;
  localparam int P  = PIPE_STAGES;

  if (P < 1 || P > 3) begin : g_bad_stages
    $error("sub_bytes_pipe: PIPE_STAGES must be 1..3");
  end

  function automatic logic [7:0] gmul8(input logic [7:0] a,
                                       input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [3:0] gmul4(input logic [3:0] a,
                                       input logic [3:0] b);
    logic [3:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
    end
    return p;
  endfunction

  // a^14 == a^-1 in GF(16), and maps 0 to 0
  function automatic logic [3:0] gf4_inv(input logic [3:0] a);
    logic [3:0] a2, a4, a8;
    a2 = gmul4(a, a);
    a4 = gmul4(a2, a2);
    a8 = gmul4(a4, a4);
    return gmul4(gmul4(a8, a4), a2);
  endfunction

  function automatic logic [7:0] lin(input logic [7:0]  x,
                                     input logic [63:0] m);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (x[i]) r = r ^ m[8*i +: 8];
    return r;
  endfunction

  function automatic logic [3:0] find_lambda();
    logic [3:0] l;
    logic       ok, hit;
    l   = '0;
    hit = 1'b0;
    for (int c = 1; c < 16; c++) begin
      ok = 1'b1;
      for (int t = 0; t < 16; t++)
        if ((gmul4(4'(t), 4'(t)) ^ 4'(t)) == 4'(c)) ok = 1'b0;
      if (ok && !hit) begin
        l   = 4'(c);
        hit = 1'b1;
      end
    end
    return l;
  endfunction

  // Columns: images in the AES field of the composite basis x^i, x^i*y
  function automatic logic [63:0] find_bmat(input logic [3:0] lam);
    logic [3:0][7:0] p;
    logic [7:0]      a, b, li, x;
    logic [63:0]     m;
    logic            ha, hb;
    a  = '0;
    ha = 1'b0;
    for (int c = 2; c < 256; c++) begin
      x = 8'(c);
      if (!ha && (gmul8(gmul8(x, x), gmul8(x, x)) ^ x) == 8'h01) begin
        a  = x;
        ha = 1'b1;
      end
    end
    p[0] = 8'h01;
    p[1] = a;
    p[2] = gmul8(a, a);
    p[3] = gmul8(p[2], a);
    li = '0;
    for (int i = 0; i < 4; i++)
      if (lam[i]) li = li ^ p[i];
    b  = '0;
    hb = 1'b0;
    for (int c = 0; c < 256; c++) begin
      x = 8'(c);
      if (!hb && (gmul8(x, x) ^ x) == li) begin
        b  = x;
        hb = 1'b1;
      end
    end
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8]     = p[i];
      m[8*i+32 +: 8]  = gmul8(p[i], b);
    end
    return m;
  endfunction

  function automatic logic [63:0] find_fmat(input logic [63:0] m);
    logic [63:0] f;
    f = '0;
    for (int i = 0; i < 8; i++)
      for (int c = 0; c < 256; c++)
        if (lin(8'(c), m) == (8'h01 << i)) f[8*i +: 8] = 8'(c);
    return f;
  endfunction

  localparam logic [3:0]  LAMBDA = find_lambda();
  localparam logic [63:0] BMAT   = find_bmat(LAMBDA);
  localparam logic [63:0] FMAT   = find_fmat(BMAT);

  function automatic logic [7:0] aff(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
           {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_aff(input logic [7:0] s);
    return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^
           {s[1:0], s[7:2]} ^ 8'h05;
  endfunction

  // {d, ah, al}: norm to invert plus the two halves for the output mul
  function automatic logic [11:0] f_mulx(input logic [7:0] b,
                                         input logic       inv);
    logic [7:0] m;
    logic [3:0] h, l, d;
    m = lin(inv ? inv_aff(b) : b, FMAT);
    h = m[7:4];
    l = m[3:0];
    d = gmul4(gmul4(h, h), LAMBDA) ^ gmul4(h, l) ^ gmul4(l, l);
    return {d, h, l};
  endfunction

  function automatic logic [11:0] f_inv(input logic [11:0] x);
    return {gf4_inv(x[11:8]), x[7:0]};
  endfunction

  function automatic logic [7:0] f_out(input logic [11:0] y,
                                       input logic        inv);
    logic [7:0] r;
    r = lin({gmul4(y[7:4], y[11:8]),
             gmul4(y[7:4] ^ y[3:0], y[11:8])}, BMAT);
    return inv ? r : aff(r);
  endfunction

  logic [P-1:0]  v, en, ld, iv;
  logic          take, in_inv_w;
  logic [XW-1:0] mx, yin;
  logic [W-1:0]  oin, od;

  always_comb begin
    en      = '0;
    en[P-1] = !v[P-1] || out_ready;
    for (int k = P - 2; k >= 0; k--)
      en[k] = !v[k] || en[k+1];
  end

  assign in_ready  = !rst && !flush && en[0];
  assign take      = in_valid && in_ready;
  assign out_valid = v[P-1];
  assign busy      = |v;
  assign out_data  = od;

  always_comb begin
    ld    = '0;
    ld[0] = take;
    for (int k = 1; k < P; k++)
      ld[k] = en[k] && v[k-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v <= '0;
    end else if (flush) begin
      v <= '0;
    end else begin
      if (en[0]) v[0] <= take;
      for (int k = 1; k < P; k++)
        if (en[k]) v[k] <= v[k-1];
    end
  end

`ifdef SBOX_INV_EN
  assign in_inv_w = in_inv;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iv <= '0;
    end else begin
      if (ld[0]) iv[0] <= in_inv;
      for (int k = 1; k < P; k++)
        if (ld[k]) iv[k] <= iv[k-1];
    end
  end
`else
  assign in_inv_w = 1'b0;
  assign iv       = '0;
`endif

  always_comb begin
    mx = '0;
    for (int l = 0; l < LANES; l++)
      mx[12*l +: 12] = f_mulx(in_data[8*l +: 8], in_inv_w);
  end

  if (P == 3) begin : g_p3
    logic [XW-1:0] xr, yr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        xr <= '0;
        yr <= '0;
      end else begin
        if (ld[0]) xr <= mx;
        if (ld[1]) yr <= yin;
      end
    end
    always_comb begin
      yin = '0;
      oin = '0;
      for (int l = 0; l < LANES; l++) begin
        yin[12*l +: 12] = f_inv(xr[12*l +: 12]);
        oin[8*l +: 8]   = f_out(yr[12*l +: 12], iv[1]);
      end
    end
  end else if (P == 2) begin : g_p2
    logic [XW-1:0] yr;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)        yr <= '0;
      else if (ld[0]) yr <= yin;
    end
    always_comb begin
      yin = '0;
      oin = '0;
      for (int l = 0; l < LANES; l++) begin
        yin[12*l +: 12] = f_inv(mx[12*l +: 12]);
        oin[8*l +: 8]   = f_out(yr[12*l +: 12], iv[0]);
      end
    end
  end else begin : g_p1
    always_comb begin
      yin = '0;
      oin = '0;
      for (int l = 0; l < LANES; l++) begin
        yin[12*l +: 12] = f_inv(mx[12*l +: 12]);
        oin[8*l +: 8]   = f_out(yin[12*l +: 12], in_inv_w);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          od <= '0;
    else if (ld[P-1]) od <= oin;
  end

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// Bench for sub_bytes_pipe: known answers, full byte sweep,
// backpressure, flush and async reset with a FIFO scoreboard.
module tb_sub_bytes_pipe;
  localparam int LANES = 4;
  localparam int P     = 2;
  localparam int W     = 8 * LANES;

  localparam logic [7:0] SBOX [256] = '{
    'h63,'h7c,'h77,'h7b,'hf2,'h6b,'h6f,'hc5,'h30,'h01,'h67,'h2b,'hfe,'hd7,'hab,'h76,
    'hca,'h82,'hc9,'h7d,'hfa,'h59,'h47,'hf0,'had,'hd4,'ha2,'haf,'h9c,'ha4,'h72,'hc0,
    'hb7,'hfd,'h93,'h26,'h36,'h3f,'hf7,'hcc,'h34,'ha5,'he5,'hf1,'h71,'hd8,'h31,'h15,
    'h04,'hc7,'h23,'hc3,'h18,'h96,'h05,'h9a,'h07,'h12,'h80,'he2,'heb,'h27,'hb2,'h75,
    'h09,'h83,'h2c,'h1a,'h1b,'h6e,'h5a,'ha0,'h52,'h3b,'hd6,'hb3,'h29,'he3,'h2f,'h84,
    'h53,'hd1,'h00,'hed,'h20,'hfc,'hb1,'h5b,'h6a,'hcb,'hbe,'h39,'h4a,'h4c,'h58,'hcf,
    'hd0,'hef,'haa,'hfb,'h43,'h4d,'h33,'h85,'h45,'hf9,'h02,'h7f,'h50,'h3c,'h9f,'ha8,
    'h51,'ha3,'h40,'h8f,'h92,'h9d,'h38,'hf5,'hbc,'hb6,'hda,'h21,'h10,'hff,'hf3,'hd2,
    'hcd,'h0c,'h13,'hec,'h5f,'h97,'h44,'h17,'hc4,'ha7,'h7e,'h3d,'h64,'h5d,'h19,'h73,
    'h60,'h81,'h4f,'hdc,'h22,'h2a,'h90,'h88,'h46,'hee,'hb8,'h14,'hde,'h5e,'h0b,'hdb,
    'he0,'h32,'h3a,'h0a,'h49,'h06,'h24,'h5c,'hc2,'hd3,'hac,'h62,'h91,'h95,'he4,'h79,
    'he7,'hc8,'h37,'h6d,'h8d,'hd5,'h4e,'ha9,'h6c,'h56,'hf4,'hea,'h65,'h7a,'hae,'h08,
    'hba,'h78,'h25,'h2e,'h1c,'ha6,'hb4,'hc6,'he8,'hdd,'h74,'h1f,'h4b,'hbd,'h8b,'h8a,
    'h70,'h3e,'hb5,'h66,'h48,'h03,'hf6,'h0e,'h61,'h35,'h57,'hb9,'h86,'hc1,'h1d,'h9e,
    'he1,'hf8,'h98,'h11,'h69,'hd9,'h8e,'h94,'h9b,'h1e,'h87,'he9,'hce,'h55,'h28,'hdf,
    'h8c,'ha1,'h89,'h0d,'hbf,'he6,'h42,'h68,'h41,'h99,'h2d,'h0f,'hb0,'h54,'hbb,'h16};

  typedef struct {
    logic [W-1:0] din;
    logic [W-1:0] dexp;
  } kat_t;

  typedef struct {
    logic [W-1:0] d;
    logic         inv;
    int           cyc;
  } sb_t;

  logic         clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0, in_inv = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [W-1:0] in_data = '0, out_data;

  int  checks = 0, failures = 0, cyc = 0;
  bit  mon_en = 0, lat_chk = 0, bp = 0;
  sb_t q[$];

  sub_bytes_pipe #(.LANES(LANES), .PIPE_STAGES(P)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SBOX_INV_EN
    .in_inv(in_inv),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] inv_s(input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      if (SBOX[i] == b) r = 8'(i);
    return r;
  endfunction

  function automatic logic [W-1:0] subx(input logic [W-1:0] d,
                                        input logic inv);
    logic [W-1:0] r;
    for (int l = 0; l < LANES; l++)
      r[8*l +: 8] = inv ? inv_s(d[8*l +: 8]) : SBOX[d[8*l +: 8]];
    return r;
  endfunction

  // Scoreboard: compares each delivered beat, stall stability, latency
  bit           stall_prev = 0;
  logic [W-1:0] held;
  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      if (stall_prev) begin
        chk("hold_valid", W'(out_valid), W'(1));
        chk("hold_data", out_data, held);
      end
      stall_prev = out_valid && !out_ready;
      held       = out_data;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_beat", out_data, 'x);
        end else begin
          sb_t e;
          e = q.pop_front();
          checks++;
          if (out_data !== e.d) begin
            failures++;
            $display("FAIL stream_data inv=%0b: got %h expected %h",
                     e.inv, out_data, e.d);
          end
          if (lat_chk) chk("latency", W'(cyc + 1 - e.cyc), W'(P));
        end
      end
    end else begin
      stall_prev = 0;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic inv);
    int   n;
    logic done;
    n        = 0;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    while (!done && n < 100) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      chk("in_ready", W'(in_ready), W'((q.size() < P) || out_ready));
      if (in_ready) begin
        q.push_back('{d: subx(d, inv), inv: in_inv, cyc: cyc + 1});
        done = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", W'(done), W'(1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (q.size() > 0 && n < 200) begin
      out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    chk("drain", W'(q.size()), W'(0));
  endtask

  task automatic fill();
    int acc;
    acc = 0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(32'h1122_3344 + i);
      #1;
      chk("fill_ready", W'(in_ready), W'(acc < P));
      if (in_ready) acc++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("full_busy", W'(busy), W'(1));
  endtask

  task automatic quiet(input string nm);
    logic seen;
    seen      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk(nm, W'(seen), W'(0));
  endtask

  initial begin
    kat_t kat[5];
    int   k;
    kat[0] = '{32'hFF53_0100, 32'h16ED_7C63};
    kat[1] = '{32'h0011_2233, 32'h6382_93C3};
    kat[2] = '{32'h1020_3040, 32'hCAB7_0409};
    kat[3] = '{32'hA5C3_5A3C, 32'h062E_BEEB};
    kat[4] = '{32'h8090_E0F0, 32'hCD60_E18C};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_out_data", out_data, '0);
    chk("rst_in_ready", W'(in_ready), W'(0));
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      in_valid  = 1'b1;
      in_data   = kat[i].din;
      out_ready = 1'b1;
      #1 chk("kat_ready", W'(in_ready), W'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      while (!out_valid && k < 20) begin
        @(posedge clk);
        @(negedge clk);
        k++;
      end
      chk("kat_latency", W'(k), W'(P));
      chk("kat_data", out_data, kat[i].dexp);
    end
    @(posedge clk);
    @(negedge clk);

    mon_en  = 1;
    lat_chk = 1;
    for (int i = 0; i < 256; i++)
      send({8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 1'b0);
    drain();
    lat_chk = 0;

    bp = 1;
    for (int i = 0; i < 10; i++)
      send(W'(32'h3C5A_96E1 * (i + 1)), 1'b0);
    drain();
    bp = 0;

`ifdef SBOX_INV_EN
    for (int i = 0; i < 6; i++)
      send((i % 2 == 1) ? {LANES{8'h63}} : '0, 1'(i % 2));
    send({LANES{8'hED}}, 1'b1);
    drain();
`endif
    mon_en = 0;
    @(negedge clk);

    fill();
    in_valid = 1'b1;
    flush    = 1'b1;
    #1 chk("flush_ready", W'(in_ready), W'(0));
    @(posedge clk);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", W'(out_valid), W'(0));
    chk("flush_busy", W'(busy), W'(0));
    quiet("flush_stale");

    fill();
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", W'(out_valid), W'(0));
    chk("arst_busy", W'(busy), W'(0));
    chk("arst_out_data", out_data, '0);
    chk("arst_in_ready", W'(in_ready), W'(0));
    @(negedge clk);
    rst = 1'b0;
    quiet("rst_stale");

    in_valid  = 1'b1;
    in_data   = 32'h0153_FF00;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    flush = 1'b1;
    #1;
    chk("fho_valid", W'(out_valid), W'(1));
    chk("fho_data", out_data, 32'h7CED_1663);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    chk("fho_after_valid", W'(out_valid), W'(0));
    chk("fho_after_busy", W'(busy), W'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
